// File: rtl/sliding_detector_pkg.sv
// Shared types and helpers for the sliding-detector sequencing controller.
package sliding_detector_pkg;

    // Per-lane decision code produced by the detector
    typedef enum logic [1:0] {
        NO_FLIP   = 2'd0,
        FLIP_CUR  = 2'd1,
        FLIP_PREV = 2'd2,
        FLIP_BOTH = 2'd3
    } flip_code_e;

    // Controller sequencing states
    typedef enum logic [1:0] {
        FILL  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        LOAD  = 2'd3
    } ctrl_state_e;

    // Code flips the bit of its own lane
    function automatic logic flips_cur(input logic [1:0] code);
        return (code == FLIP_CUR) || (code == FLIP_BOTH);
    endfunction

    // Code flips the bit of the lane below (or the previous frame's top bit)
    function automatic logic flips_prev(input logic [1:0] code);
        return (code == FLIP_PREV) || (code == FLIP_BOTH);
    endfunction

    // Unsigned add clamped to max_val
    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [31:0] max_val);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum > {1'b0, max_val}) return max_val;
        return sum[31:0];
    endfunction

endpackage

// File: rtl/flip_mask_gen.sv
// Turns one frame's worth of decision codes into a flip mask for the frame
// under evaluation plus the flip of the previous frame's top bit.
module flip_mask_gen
    import sliding_detector_pkg::*;
#(
    parameter int width = 16
) (
    input  logic [width-1:0][1:0] i_codes,
    output logic [width-1:0]      o_mask,
    output logic                  o_boundary_flip
);

    logic [width-1:0] w_cur;
    logic [width:0]   w_prev;  // w_prev[width] is the implicit code above the top lane

    // Decode each lane's code and combine own-lane and lane-above flips
    always_comb begin
        // NOTE: every output gets a default before the loops, so no path leaves one unassigned and no latch is inferred.
        w_cur           = '0;
        w_prev          = '0;
        o_mask          = '0;
        o_boundary_flip = 1'b0;
        for (int i = 0; i < width; i++) begin
            w_cur[i]  = flips_cur(i_codes[i]);
            w_prev[i] = flips_prev(i_codes[i]);
        end
        for (int i = 0; i < width; i++) begin
            o_mask[i] = w_cur[i] ^ w_prev[i+1];
        end
        o_boundary_flip = w_prev[0];
    end

endmodule

// File: rtl/sliding_detector_ctrl.sv
// Sequencing controller around the combinational sliding detector: frame
// window, channel-estimate hold with update handshake, and corrected output.
module sliding_detector_ctrl
    import sliding_detector_pkg::*;
#(
    parameter int width                  = 16,
    parameter int depth                  = 30,
    parameter int est_error_bitwidth     = 8,
    parameter int est_channel_bitwidth   = 8,
    parameter int sliding_detector_depth = 2,
    parameter int t0_buff                = 1,
    parameter int flip_cnt_width         = 16
) (
    input  logic                                                   clk,
    input  logic                                                   rstb,
    input  logic                                                   en,
    input  logic                                                   in_valid,
    output logic                                                   in_ready,
    input  logic [width-1:0][est_error_bitwidth-1:0]               errstream_in,
    input  logic [width-1:0]                                       bitstream_in,
    input  logic                                                   chan_upd_valid,
    output logic                                                   chan_upd_ready,
    input  logic [width-1:0][depth-1:0][est_channel_bitwidth-1:0]  chan_upd_data,
    output logic [width*sliding_detector_depth-1:0][est_error_bitwidth-1:0] det_errstream,
    output logic [width*sliding_detector_depth-1:0]                det_bitstream,
    output logic [width-1:0][depth-1:0][est_channel_bitwidth-1:0]  det_channel,
    input  logic [width-1:0][1:0]                                  det_mmse_err_pos,
    output logic                                                   out_valid,
    output logic [width-1:0]                                       corr_bitstream,
    output logic [flip_cnt_width-1:0]                              flip_count
);

    localparam int WIN    = width * sliding_detector_depth;
    localparam int FILL_W = $clog2(sliding_detector_depth + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(sliding_detector_depth);
    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(sliding_detector_depth - 1);
    localparam logic [31:0]       CNT_MAX   = 32'({flip_cnt_width{1'b1}});

    ctrl_state_e r_state, w_state_next;
    logic        w_in_ready;
    logic        w_accept;
    logic        r_chan_upd_ready;

    logic [FILL_W-1:0] r_fill_cnt;
    logic              r_eval;

    logic [WIN-1:0][est_error_bitwidth-1:0]                  r_win_err;
    logic [WIN-1:0]                                          r_win_bit;
    logic [width-1:0][depth-1:0][est_channel_bitwidth-1:0]   r_channel;

    logic [width-1:0][1:0] w_codes;
    logic [width-1:0]      w_mask;
    logic                  w_boundary_flip;
    logic [width-1:0]      w_boundary_vec;
    logic [width-1:0]      w_eval_frame;
    logic [width-1:0]      w_emit_flips;
    logic                  w_emit;

    logic                      r_have_pend;
    logic [width-1:0]          r_pend;
    logic [width-1:0]          r_pend_mask;
    logic                      r_out_valid;
    logic [width-1:0]          r_corr;
    logic [flip_cnt_width-1:0] r_flip_count;

    assign w_accept = in_valid && w_in_ready;

    // State register; the load strobe is registered from the next state
    always_ff @(posedge clk or negedge rstb) begin
        // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of statement order.
        if (!rstb) begin
            r_state          <= FILL;
            r_chan_upd_ready <= 1'b0;
        end else begin
            r_state          <= w_state_next;
            r_chan_upd_ready <= (w_state_next == LOAD);
        end
    end

    // Next-state: hold off channel updates until the window is full, then
    // drain one cycle and load
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            FILL:    if (r_fill_cnt == FILL_FULL || (w_accept && r_fill_cnt == FILL_LAST))
                         w_state_next = RUN;
            RUN:     if (chan_upd_valid) w_state_next = DRAIN;
            DRAIN:   w_state_next = LOAD;
            LOAD:    w_state_next = (r_fill_cnt < FILL_FULL) ? FILL : RUN;
            default: w_state_next = FILL;
        endcase
    end

    // Output decode: input is refused from the cycle an update is seen
    // through the drain cycle
    always_comb begin
        w_in_ready = 1'b0;
        unique case (r_state)
            FILL:    w_in_ready = 1'b1;
            RUN:     w_in_ready = !chan_upd_valid;
            DRAIN:   w_in_ready = 1'b0;
            LOAD:    w_in_ready = 1'b1;
            default: w_in_ready = 1'b0;
        endcase
    end

    // Window shift, fill count, evaluation strobe and channel capture
    always_ff @(posedge clk or negedge rstb) begin
        // NOTE: the window and channel are plain flops rather than a RAM, so they are cleared on reset and det_* is defined from the first cycle.
        if (!rstb) begin
            r_win_err  <= '0;
            r_win_bit  <= '0;
            r_fill_cnt <= '0;
            r_eval     <= 1'b0;
            r_channel  <= '0;
        end else begin
            if (w_accept) begin
                r_win_err <= {errstream_in, r_win_err[WIN-1:width]};
                r_win_bit <= {bitstream_in, r_win_bit[WIN-1:width]};
                if (r_fill_cnt != FILL_FULL) r_fill_cnt <= r_fill_cnt + 1'b1;
            end
            r_eval <= w_accept && (r_fill_cnt >= FILL_LAST);
            if (r_state == LOAD) r_channel <= chan_upd_data;
        end
    end

    // Bypass forces every code to "no flip" without changing latency
    assign w_codes = en ? det_mmse_err_pos : '0;

    flip_mask_gen #(
        .width(width)
    ) u_flip_mask_gen (
        .i_codes         (w_codes),
        .o_mask          (w_mask),
        .o_boundary_flip (w_boundary_flip)
    );

    assign w_eval_frame   = r_win_bit[t0_buff*width +: width];
    assign w_boundary_vec = {w_boundary_flip, {(width-1){1'b0}}};
    assign w_emit         = r_eval && r_have_pend;
    assign w_emit_flips   = r_pend_mask ^ w_boundary_vec;

    // On each evaluation: park the corrected frame, emit the previous one
    // with its top-bit fix, and accumulate the flips actually applied
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_have_pend  <= 1'b0;
            r_pend       <= '0;
            r_pend_mask  <= '0;
            r_out_valid  <= 1'b0;
            r_corr       <= '0;
            r_flip_count <= '0;
        end else begin
            r_out_valid <= w_emit;
            if (r_eval) begin
                r_pend      <= w_eval_frame ^ w_mask;
                r_pend_mask <= w_mask;
                r_have_pend <= 1'b1;
            end
            if (w_emit) begin
                r_corr       <= r_pend ^ w_boundary_vec;
                r_flip_count <= flip_cnt_width'(sat_add(32'(r_flip_count),
                                                        32'($countones(w_emit_flips)),
                                                        CNT_MAX));
            end
        end
    end

    assign in_ready       = w_in_ready;
    assign chan_upd_ready = r_chan_upd_ready;
    assign det_errstream  = r_win_err;
    assign det_bitstream  = r_win_bit;
    assign det_channel    = r_channel;
    assign out_valid      = r_out_valid;
    assign corr_bitstream = r_corr;
    assign flip_count     = r_flip_count;

endmodule
